rpxx_xfer_seq: RTL and testbench

Sector transfer sequencer for the RPxx disk emulation. It runs a read or write data transfer against the disk address registers, which hold the sector, track and cylinder counters. It counts words within each sector, pulses sector-increment and cylinder-increment, and terminates on word-count exhaustion, abort or end-of-disk. It sits between the RPxx command decoder and the data buffer / SD DMA path.

---
 rtl/rpxx_xfer_seq.sv | 174 +++++++++++++++++
 tb/tb_rpxx_xfer_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rpxx_xfer_seq.sv
// rpxx_xfer_seq -- RPxx sector transfer sequencer.
//
// Runs one read or write transfer of rpWC 36-bit words against the disk
// address registers. Words are counted within each sector; a completed
// sector pulses rpINCSECT (and rpINCCYL when the sector/track wrap), and the
// transfer ends on word-count exhaustion, abort or end-of-disk (rpAOE).
//
// Optional feature: define RPXX_ZFILL_EN to pad a short final sector with
// wordPAD words so that it is always completed and counted.
//
// Handshake: wordREQ is a registered request that stays high through stalls;
// a word moves on every rising edge where wordREQ and wordACK are both high.
// wordREQ never depends combinationally on wordACK.

module rpxx_xfer_seq #(
    parameter int WPS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rpGO,
    input  logic        rpWRITE,
    input  logic        rpABORT,
    input  logic [15:0] rpWC,
    input  logic [5:0]  rpSA,
    input  logic [5:0]  rpTA,
    input  logic [5:0]  rpSECNUM,
    input  logic [5:0]  rpTRKNUM,
    input  logic [9:0]  rpCA,
    input  logic [9:0]  rpCYLNUM,
    input  logic        wordACK,
    output logic        wordREQ,
    output logic        wordPAD,
    output logic        rpINCSECT,
    output logic        rpINCCYL,
    output logic        rpBUSY,
    output logic        rpDONE,
    output logic        rpAOE,
    output logic        rpDIR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_EOS  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] SWC_LAST = 8'(WPS - 1);

    // Current state; observable hierarchically for debug and checkers.
    state_t      state;
    logic [15:0] wc;
    logic [7:0]  swc;

    logic        hs;
    logic [15:0] wc_dec;
    logic        sect_end;
    logic        wrap;
    logic        cyl_last;

    // Word handshake and the arithmetic/compare terms used by the FSM.
    always_comb begin
        hs       = (state == S_XFER) && wordREQ && wordACK;
        wc_dec   = (wc != 16'd0) ? (wc - 16'd1) : 16'd0;
        sect_end = (swc == SWC_LAST);
        wrap     = (rpSA == rpSECNUM) && (rpTA == rpTRKNUM);
        cyl_last = (rpCA == rpCYLNUM);
    end

    // Transfer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wc        <= 16'd0;
            swc       <= 8'd0;
            wordREQ   <= 1'b0;
            wordPAD   <= 1'b0;
            rpINCSECT <= 1'b0;
            rpINCCYL  <= 1'b0;
            rpBUSY    <= 1'b0;
            rpDONE    <= 1'b0;
            rpAOE     <= 1'b0;
            rpDIR     <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to 0 unless set below.
            rpINCSECT <= 1'b0;
            rpINCCYL  <= 1'b0;
            rpDONE    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rpGO) begin
                        rpAOE <= 1'b0;
                        if (rpWC != 16'd0) begin
                            wc      <= rpWC;
                            rpDIR   <= rpWRITE;
                            swc     <= 8'd0;
                            state   <= S_XFER;
                            wordREQ <= 1'b1;
                            wordPAD <= 1'b0;
                            rpBUSY  <= 1'b1;
                        end else begin
                            // Zero-length transfer completes immediately.
                            state  <= S_DONE;
                            rpDONE <= 1'b1;
                        end
                    end
                end

                S_XFER: begin
                    if (rpABORT) begin
                        // Partial sector is abandoned without any increment.
                        state   <= S_DONE;
                        rpDONE  <= 1'b1;
                        wordREQ <= 1'b0;
                        wordPAD <= 1'b0;
                        rpBUSY  <= 1'b0;
                    end else if (hs) begin
                        wc <= wc_dec;
                        if (sect_end) begin
                            swc       <= 8'd0;
                            state     <= S_EOS;
                            wordREQ   <= 1'b0;
                            wordPAD   <= 1'b0;
                            rpINCSECT <= 1'b1;
                            // On the last cylinder with words left the
                            // transfer overflows instead of stepping cylinder.
                            rpINCCYL  <= wrap && !(cyl_last && (wc_dec != 16'd0));
                        end else begin
                            swc <= swc + 8'd1;
                            if (wc_dec == 16'd0) begin
`ifdef RPXX_ZFILL_EN
                                // Finish the sector with pad words.
                                wordPAD <= 1'b1;
`else
                                // Short final sector: stop without EOS.
                                state   <= S_DONE;
                                rpDONE  <= 1'b1;
                                wordREQ <= 1'b0;
                                wordPAD <= 1'b0;
                                rpBUSY  <= 1'b0;
`endif
                            end
                        end
                    end
                end

                S_EOS: begin
                    if (rpABORT || (wrap && cyl_last && (wc != 16'd0)) || (wc == 16'd0)) begin
                        if (!rpABORT && wrap && cyl_last && (wc != 16'd0)) begin
                            rpAOE <= 1'b1;
                        end
                        state   <= S_DONE;
                        rpDONE  <= 1'b1;
                        wordREQ <= 1'b0;
                        rpBUSY  <= 1'b0;
                    end else begin
                        state   <= S_XFER;
                        wordREQ <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpxx_xfer_seq.sv
// tb_rpxx_xfer_seq -- self-checking bench for rpxx_xfer_seq.
// Each transfer is predicted word by word from the sector rules (handshake
// count, pad flags, sector/cylinder pulses, overflow, completion cycle) and
// the DUT outputs are compared against that prediction.

module tb_rpxx_xfer_seq;

    localparam int WPS = 128;

    logic        clk;
    logic        rst;
    logic        rpGO;
    logic        rpWRITE;
    logic        rpABORT;
    logic [15:0] rpWC;
    logic [5:0]  rpSA;
    logic [5:0]  rpTA;
    logic [5:0]  rpSECNUM;
    logic [5:0]  rpTRKNUM;
    logic [9:0]  rpCA;
    logic [9:0]  rpCYLNUM;
    logic        wordACK;
    logic        wordREQ;
    logic        wordPAD;
    logic        rpINCSECT;
    logic        rpINCCYL;
    logic        rpBUSY;
    logic        rpDONE;
    logic        rpAOE;
    logic        rpDIR;

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_q[$];

    rpxx_xfer_seq #(.WPS(WPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .rpGO      (rpGO),
        .rpWRITE   (rpWRITE),
        .rpABORT   (rpABORT),
        .rpWC      (rpWC),
        .rpSA      (rpSA),
        .rpTA      (rpTA),
        .rpSECNUM  (rpSECNUM),
        .rpTRKNUM  (rpTRKNUM),
        .rpCA      (rpCA),
        .rpCYLNUM  (rpCYLNUM),
        .wordACK   (wordACK),
        .wordREQ   (wordREQ),
        .wordPAD   (wordPAD),
        .rpINCSECT (rpINCSECT),
        .rpINCCYL  (rpINCCYL),
        .rpBUSY    (rpBUSY),
        .rpDONE    (rpDONE),
        .rpAOE     (rpAOE),
        .rpDIR     (rpDIR)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_addr(input int sa, input int secn, input int ta, input int trkn,
                            input int ca, input int cyln);
        rpSA     = 6'(sa);
        rpSECNUM = 6'(secn);
        rpTA     = 6'(ta);
        rpTRKNUM = 6'(trkn);
        rpCA     = 10'(ca);
        rpCYLNUM = 10'(cyln);
    endtask

    // One transfer: predict, drive, observe, compare.
    // abort_at < 0 means no abort; go_mid pulses rpGO during the transfer.
    task automatic run_xfer(input int wc, input bit wr, input int abort_at,
                            input int ack_pct, input bit go_mid);
        int  rem, pos, h, sect, cyl, exp_done;
        bit  aoe, last_eos, aborted, zf, wrap, cl;
        int  obs_h, obs_sect, obs_cyl, done_cyc, last_ack_cyc, abort_cyc;
        bit  abort_sent;
        logic [0:0] e;

`ifdef RPXX_ZFILL_EN
        zf = 1'b1;
`else
        zf = 1'b0;
`endif
        wrap = (rpSA == rpSECNUM) && (rpTA == rpTRKNUM);
        cl   = (rpCA == rpCYLNUM);

        // Reference model: walk the words of the transfer.
        exp_q.delete();
        rem = wc; pos = 0; h = 0; sect = 0; cyl = 0;
        aoe = 0; last_eos = 0; aborted = 0;
        if (wc > 0) begin
            while (1) begin
                if (h == abort_at) begin
                    aborted = 1;
                    break;
                end
                exp_q.push_back(rem == 0);
                h++;
                if (rem > 0) rem--;
                pos++;
                if (pos == WPS) begin
                    pos = 0;
                    sect++;
                    last_eos = 1;
                    if (wrap && cl && rem != 0) begin
                        aoe = 1;
                        break;
                    end
                    if (wrap) cyl++;
                    if (rem == 0) break;
                end else begin
                    last_eos = 0;
                    if (rem == 0 && !zf) break;
                end
            end
        end

        // Start the transfer.
        @(negedge clk);
        rpGO = 1'b1; rpWC = 16'(wc); rpWRITE = wr; rpABORT = 1'b0; wordACK = 1'b0;

        obs_h = 0; obs_sect = 0; obs_cyl = 0; done_cyc = -1;
        last_ack_cyc = 0; abort_cyc = 0; abort_sent = 0;
        for (int it = 1; it <= 3000; it++) begin
            @(negedge clk);
            rpGO = 1'b0; rpABORT = 1'b0; wordACK = 1'b0;
            if (it == 1) begin
                check("busy_start", rpBUSY, wc != 0);
                check("req_start", wordREQ, wc != 0);
                check("aoe_clear", rpAOE, 0);
                if (wc != 0) check("dir", rpDIR, wr);
            end
            if (go_mid && it == 5) begin
                rpGO = 1'b1; rpWC = 16'($urandom_range(1, 50)); rpWRITE = ~wr;
            end
            if (rpINCSECT) obs_sect++;
            if (rpINCCYL) begin
                obs_cyl++;
                check("cyl_with_sect", rpINCSECT, 1);
            end
            if (rpDONE) begin
                done_cyc = it;
                break;
            end
            if (!abort_sent && abort_at >= 0 && obs_h == abort_at && rpBUSY) begin
                rpABORT = 1'b1;
                abort_sent = 1;
                abort_cyc = it;
            end else begin
                wordACK = ($urandom_range(99) < ack_pct);
            end
            if (wordACK && wordREQ) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pad", wordPAD, e);
                end
                obs_h++;
                last_ack_cyc = it;
            end
        end
        wordACK = 1'b0;

        if (wc == 0)      exp_done = 1;
        else if (aborted) exp_done = abort_cyc + 1;
        else if (last_eos) exp_done = last_ack_cyc + 2;
        else              exp_done = last_ack_cyc + 1;

        if (done_cyc < 0) check("timeout", 0, 1);
        check("words", obs_h, h);
        check("left_words", exp_q.size(), 0);
        check("incsect", obs_sect, sect);
        check("inccyl", obs_cyl, cyl);
        check("aoe", rpAOE, aoe);
        check("done_cycle", done_cyc, exp_done);

        @(negedge clk);
        check("done_pulse", rpDONE, 0);
        check("idle_busy", rpBUSY, 0);
        check("idle_req", wordREQ, 0);
    endtask

    initial begin
        int wc, ab, pct;
        rst = 1'b1; rpGO = 1'b0; rpWRITE = 1'b0; rpABORT = 1'b0; rpWC = 16'd0;
        wordACK = 1'b0;
        set_addr(0, 19, 0, 18, 5, 814);
        repeat (3) @(negedge clk);
        check("reset_outs", {wordREQ, wordPAD, rpINCSECT, rpINCCYL, rpBUSY, rpDONE, rpAOE, rpDIR}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_xfer(256, 1'b0, -1, 100, 1'b0);
        run_xfer(130, 1'b1, -1, 100, 1'b0);
        set_addr(19, 19, 18, 18, 5, 814);
        run_xfer(128, 1'b0, -1, 100, 1'b0);
        set_addr(19, 19, 18, 18, 814, 814);
        run_xfer(200, 1'b1, -1, 100, 1'b0);
        set_addr(0, 19, 0, 18, 5, 814);
        run_xfer(64, 1'b0, -1, 100, 1'b0);
        run_xfer(300, 1'b0, 50, 100, 1'b0);
        run_xfer(200, 1'b1, -1, 70, 1'b1);
        run_xfer(0, 1'b1, -1, 100, 1'b0);
        run_xfer(1, 1'b0, -1, 40, 1'b0);

        // Randomized transfers
        for (int n = 0; n < 10; n++) begin
            wc  = $urandom_range(1, 400);
            pct = $urandom_range(40, 100);
            if ($urandom_range(1)) set_addr(7, 7, 3, 3, 0, 0);
            else set_addr($urandom_range(0, 30), 31, $urandom_range(0, 30), 31, 0, 0);
            rpCYLNUM = $urandom_range(1) ? 10'd0 : 10'd9;
            ab = -1;
            if (wc > 2 && $urandom_range(2) == 0) begin
                ab = $urandom_range(1, wc - 1);
                if (ab % WPS == 0) ab = ab - 1;
            end
            run_xfer(wc, 1'($urandom_range(1)), ab, pct, 1'b0);
        end

        // Reset in the middle of a transfer
        set_addr(0, 19, 0, 18, 5, 814);
        @(negedge clk);
        rpGO = 1'b1; rpWC = 16'd300; rpWRITE = 1'b1;
        @(negedge clk);
        rpGO = 1'b0; wordACK = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_busy", rpBUSY, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", {wordREQ, wordPAD, rpINCSECT, rpINCCYL, rpBUSY, rpDONE, rpAOE, rpDIR}, 0);
        rst = 1'b0; wordACK = 1'b0;
        @(negedge clk);
        check("post_rst_outs", {wordREQ, wordPAD, rpINCSECT, rpINCCYL, rpBUSY, rpDONE, rpAOE, rpDIR}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
